// File: rtl/pearson_nonce_search.sv
// Nonce sweep controller for the Pearson hash core: builds {block_data, nonce},
// clears and runs the core per attempt, and compares each result to the target.
module pearson_nonce_search #(
    parameter int TIMEOUT      = 64,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] block_data,
    input  logic [7:0]  target,
    input  logic [31:0] nonce_start,
    input  logic [31:0] nonce_limit,
    output logic [63:0] hash_message,
    output logic        hash_enable,
    output logic        hash_reset_n,
    input  logic [7:0]  hash_in,
    input  logic        hash_finished,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [31:0] found_nonce,
    output logic [7:0]  found_hash,
    output logic        exhausted,
    output logic        timeout_err,
    output logic        aborted,
    output logic [31:0] attempts
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int CL_W = $clog2(CLEAR_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_RUN, S_CHECK, S_FOUND, S_EXHAUSTED, S_ERROR
    } state_t;

    typedef struct packed {
        logic [31:0] block;
        logic [7:0]  target;
        logic [31:0] limit;
    } search_req_t;

    state_t      state_q, state_d;
    search_req_t req_q;
    logic [31:0] nonce_q;
    logic [7:0]  hash_q;
    logic [WD_W-1:0] wdog_q;
    logic [CL_W-1:0] clr_cnt_q;
    logic        abort;
    logic        clear_last, wdog_last, hit, at_limit;

    // stop overrides every other event once a search is under way
    assign abort      = stop && (state_q != S_IDLE);
    assign clear_last = (clr_cnt_q == CL_W'(CLEAR_CYCLES - 1));
    assign wdog_last  = (wdog_q == WD_W'(TIMEOUT - 1));
    assign hit        = (hash_q < req_q.target);
    assign at_limit   = (nonce_q == req_q.limit);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start && !stop) state_d = S_CLEAR;
                S_CLEAR: if (clear_last) state_d = S_RUN;
                S_RUN: begin
                    if (hash_finished)  state_d = S_CHECK;
                    else if (wdog_last) state_d = S_ERROR;
                end
                S_CHECK: begin
                    if (hit)           state_d = S_FOUND;
                    else if (at_limit) state_d = S_EXHAUSTED;
                    else               state_d = S_CLEAR;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy         = (state_q != S_IDLE);
        hash_enable  = (state_q == S_RUN) && !stop;
        hash_reset_n = (state_q == S_RUN) || (state_q == S_CHECK);
        done         = ((state_q == S_FOUND) || (state_q == S_EXHAUSTED) ||
                        (state_q == S_ERROR)) && !stop;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_q        <= '0;
            nonce_q      <= '0;
            hash_q       <= '0;
            wdog_q       <= '0;
            clr_cnt_q    <= '0;
            hash_message <= '0;
            found        <= 1'b0;
            found_nonce  <= '0;
            found_hash   <= '0;
            exhausted    <= 1'b0;
            timeout_err  <= 1'b0;
            aborted      <= 1'b0;
            attempts     <= '0;
        end else begin
            aborted <= abort;
            if (!abort) begin
                case (state_q)
                    S_IDLE: begin
                        clr_cnt_q <= '0;
                        if (start && !stop) begin
                            req_q       <= '{block: block_data, target: target, limit: nonce_limit};
                            nonce_q     <= nonce_start;
                            attempts    <= '0;
                            found       <= 1'b0;
                            found_nonce <= '0;
                            found_hash  <= '0;
                            exhausted   <= 1'b0;
                            timeout_err <= 1'b0;
                        end
                    end
                    S_CLEAR: begin
                        clr_cnt_q    <= clr_cnt_q + 1'b1;
                        hash_message <= {req_q.block, nonce_q};
                        wdog_q       <= '0;
                    end
                    S_RUN: begin
                        wdog_q <= wdog_q + 1'b1;
                        if (hash_finished) begin
                            hash_q <= hash_in;
                            if (attempts != 32'hFFFF_FFFF) attempts <= attempts + 1'b1;
                        end else if (wdog_last) begin
                            timeout_err <= 1'b1;
                        end
                    end
                    S_CHECK: begin
                        clr_cnt_q <= '0;
                        if (hit) begin
                            found       <= 1'b1;
                            found_nonce <= nonce_q;
                            found_hash  <= hash_q;
                        end else if (at_limit) begin
                            exhausted <= 1'b1;
                        end else begin
                            nonce_q <= nonce_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
